// File: rtl/ps2_host_tx_if.sv
// Command-side handshake of the PS/2 host transmitter: byte request in, status out.
// The requester uses the master modport and the transmitter uses the slave modport.
interface ps2_host_tx_if;
  logic [7:0] TX_DATA;
  logic       TX_START;
  logic       BUSY;
  logic       DONE;
  logic       ERROR;
  logic [1:0] ERR_CODE;

  modport master (output TX_DATA, TX_START, input BUSY, DONE, ERROR, ERR_CODE);
  modport slave  (input TX_DATA, TX_START, output BUSY, DONE, ERROR, ERR_CODE);
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, clocks one command byte out on
// device falling edges, checks the device ACK and drives the pads open-drain via OE lines.

// Pad conditioner: 2-FF synchroniser followed by a run-length glitch filter.
module ps2_host_tx_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pad,
  output logic o_level
);
  localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          w_differs;

  assign w_differs = r_sync[1] ^ r_level;
  assign o_level   = r_level;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, exactly like the hardware flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_pad};
      if (!w_differs) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
        r_cnt   <= '0;
        r_level <= ~r_level;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 3200,
  parameter int START_TIMEOUT  = 480000,
  parameter int BIT_TIMEOUT    = 64000,
  parameter int FILTER_LEN     = 8
) (
  input  logic            CLK,
  input  logic            nRESET,
  input  logic            PS2_CLK,
  input  logic            PS2_DATA,
  output logic            PS2_CLK_OE,
  output logic            PS2_DATA_OE,
  ps2_host_tx_if.slave    bus
);
  localparam int TW = 19;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_START = 2'd1;
  localparam logic [1:0] ERR_BIT   = 2'd2;
  localparam logic [1:0] ERR_NACK  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t        r_state,    w_state_nxt;
  logic [9:0]    r_shift,    w_shift_nxt;
  logic [3:0]    r_edge,     w_edge_nxt;
  logic [TW-1:0] r_timer,    w_timer_nxt;
  logic          r_data_oe,  w_data_oe_nxt;
  logic          r_busy,     w_busy_nxt;
  logic          r_done,     w_done_nxt;
  logic          r_error,    w_error_nxt;
  logic [1:0]    r_err_code, w_err_code_nxt;
  logic          r_clk_prev;

  logic          w_clk_level, w_data_level, w_clk_fall;
  logic          w_fail;
  logic [1:0]    w_fail_code;
  logic          w_inhibit_last, w_bit_timeout;

  ps2_host_tx_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk(CLK), .rst_n(nRESET), .i_pad(PS2_CLK), .o_level(w_clk_level)
  );

  ps2_host_tx_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk(CLK), .rst_n(nRESET), .i_pad(PS2_DATA), .o_level(w_data_level)
  );

  assign w_clk_fall     = r_clk_prev & ~w_clk_level;
  assign w_inhibit_last = (r_timer == TW'(INHIBIT_CYCLES - 1));
  assign w_bit_timeout  = (r_timer == TW'(BIT_TIMEOUT - 1));

  // Pad enables decode from the state so a fail or reset releases both pads at once.
  assign PS2_CLK_OE  = (r_state == S_INHIBIT);
  assign PS2_DATA_OE = ((r_state == S_INHIBIT) && w_inhibit_last) ||
                       (r_state == S_REQ) ||
                       ((r_state == S_SEND) && r_data_oe);

  assign bus.BUSY     = r_busy;
  assign bus.DONE     = r_done;
  assign bus.ERROR    = r_error;
  assign bus.ERR_CODE = r_err_code;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_edge_nxt     = r_edge;
    w_timer_nxt    = r_timer;
    w_data_oe_nxt  = r_data_oe;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_error_nxt    = 1'b0;
    w_err_code_nxt = r_err_code;
    w_fail         = 1'b0;
    w_fail_code    = ERR_NONE;

    unique case (r_state)
      S_IDLE: begin
        // A request landing on the DONE/ERROR pulse cycle is deliberately dropped.
        if (bus.TX_START && !r_done && !r_error) begin
          w_state_nxt    = S_INHIBIT;
          w_shift_nxt    = {1'b1, ~^bus.TX_DATA, bus.TX_DATA};
          w_edge_nxt     = '0;
          w_timer_nxt    = '0;
          w_data_oe_nxt  = 1'b0;
          w_busy_nxt     = 1'b1;
          w_err_code_nxt = ERR_NONE;
        end
      end

      S_INHIBIT: begin
        if (w_inhibit_last) begin
          w_state_nxt = S_REQ;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end

      S_REQ: begin
        if (w_clk_fall) begin
          w_data_oe_nxt = ~r_shift[0];
          w_shift_nxt   = {1'b0, r_shift[9:1]};
          w_edge_nxt    = 4'd1;
          w_timer_nxt   = '0;
          w_state_nxt   = S_SEND;
        end else if (r_timer == TW'(START_TIMEOUT - 1)) begin
          w_fail      = 1'b1;
          w_fail_code = ERR_START;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end

      S_SEND: begin
        if (w_clk_fall) begin
          w_data_oe_nxt = ~r_shift[0];
          w_shift_nxt   = {1'b0, r_shift[9:1]};
          w_edge_nxt    = r_edge + 4'd1;
          w_timer_nxt   = '0;
          if (r_edge == 4'd9) w_state_nxt = S_ACK;
        end else if (w_bit_timeout) begin
          w_fail      = 1'b1;
          w_fail_code = ERR_BIT;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end

      S_ACK: begin
        if (w_clk_fall) begin
          w_edge_nxt  = r_edge + 4'd1;
          w_timer_nxt = '0;
          if (!w_data_level) begin
            w_state_nxt = S_WAIT_IDLE;
          end else begin
            w_fail      = 1'b1;
            w_fail_code = ERR_NACK;
          end
        end else if (w_bit_timeout) begin
          w_fail      = 1'b1;
          w_fail_code = ERR_BIT;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end

      S_WAIT_IDLE: begin
        if (w_clk_level && w_data_level) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
        end else if (w_bit_timeout) begin
          w_fail      = 1'b1;
          w_fail_code = ERR_BIT;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase

    if (w_fail) begin
      w_state_nxt    = S_IDLE;
      w_data_oe_nxt  = 1'b0;
      w_busy_nxt     = 1'b0;
      w_error_nxt    = 1'b1;
      w_err_code_nxt = w_fail_code;
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_edge     <= '0;
      r_timer    <= '0;
      r_data_oe  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_err_code <= ERR_NONE;
      r_clk_prev <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_edge     <= w_edge_nxt;
      r_timer    <= w_timer_nxt;
      r_data_oe  <= w_data_oe_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_error    <= w_error_nxt;
      r_err_code <= w_err_code_nxt;
      r_clk_prev <= w_clk_level;
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a keyboard model clocks frames and ACKs, and a
// scoreboard monitor compares every DONE/ERROR pulse against queued expectations.
module tb_ps2_host_tx;
  localparam int HALF = 40;

  typedef struct {
    logic       is_err;
    logic [1:0] code;
    logic       chk_bits;
    logic [10:0] bits;
  } exp_t;

  logic CLK = 1'b0;
  logic nRESET = 1'b0;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  logic PS2_CLK_OE, PS2_DATA_OE;
  logic ps2_clk_pad, ps2_data_pad;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          resp_cnt = 0;
  int          exp_total = 0;
  logic [10:0] dev_bits;

  ps2_host_tx_if bus();

  assign ps2_clk_pad  = ~(PS2_CLK_OE | dev_clk_low);
  assign ps2_data_pad = ~(PS2_DATA_OE | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(20), .START_TIMEOUT(500), .BIT_TIMEOUT(300), .FILTER_LEN(8)
  ) dut (
    .CLK(CLK), .nRESET(nRESET),
    .PS2_CLK(ps2_clk_pad), .PS2_DATA(ps2_data_pad),
    .PS2_CLK_OE(PS2_CLK_OE), .PS2_DATA_OE(PS2_DATA_OE),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic is_err, input logic [1:0] code,
                          input logic chk_bits, input logic [10:0] bits);
    exp_t e;
    e.is_err = is_err; e.code = code; e.chk_bits = chk_bits; e.bits = bits;
    exp_q.push_back(e);
    exp_total++;
  endtask

  // Scoreboard monitor: every DONE/ERROR pulse must match the oldest expectation.
  always @(negedge CLK) begin
    if (bus.DONE || bus.ERROR) begin
      resp_cnt++;
      check("done_error_exclusive", 32'(bus.DONE & bus.ERROR), 0);
      check("resp_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("resp_is_error", 32'(bus.ERROR), 32'(mon_e.is_err));
        check("resp_err_code", 32'(bus.ERR_CODE), 32'(mon_e.code));
        check("resp_busy_low", 32'(bus.BUSY), 0);
        if (mon_e.is_err) check("resp_oe_released", {30'd0, PS2_CLK_OE, PS2_DATA_OE}, 0);
        if (mon_e.chk_bits) check("resp_frame_bits", 32'(dev_bits), 32'(mon_e.bits));
      end
    end
  end

  task automatic send(input logic [7:0] d);
    @(negedge CLK);
    bus.TX_DATA  = d;
    bus.TX_START = 1'b1;
    @(negedge CLK);
    bus.TX_START = 1'b0;
    check("busy_after_accept", 32'(bus.BUSY), 1);
    check("err_code_cleared", 32'(bus.ERR_CODE), 0);
  endtask

  task automatic wait_resp(input int limit);
    int t = 0;
    while (resp_cnt < exp_total && t < limit) begin
      @(negedge CLK);
      t++;
    end
    check("resp_within_budget", 32'(resp_cnt >= exp_total), 1);
  endtask

  // Keyboard model: samples the start bit before clocking, then data on each rising edge.
  task automatic dev_frame(input int n_clk, input bit ack, input int glitch_at);
    int t;
    dev_bits = '0;
    t = 0;
    while (!PS2_CLK_OE && t < 200) begin @(negedge CLK); t++; end
    check("dev_saw_inhibit", 32'(PS2_CLK_OE), 1);
    t = 0;
    while (PS2_CLK_OE && t < 200) begin @(negedge CLK); t++; end
    check("dev_saw_release", 32'(PS2_CLK_OE), 0);
    repeat (30) @(negedge CLK);
    dev_bits[0] = ps2_data_pad;
    for (int i = 1; i <= n_clk; i++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge CLK);
      dev_clk_low = 1'b0;
      if (i <= 10) dev_bits[i] = ps2_data_pad;
      dev_data_low = ack && (i == 10);
      if (i == glitch_at) begin
        repeat (10) @(negedge CLK);
        dev_clk_low = 1'b1;
        repeat (3) @(negedge CLK);
        dev_clk_low = 1'b0;
        repeat (HALF - 13) @(negedge CLK);
      end else begin
        repeat (HALF) @(negedge CLK);
      end
    end
  endtask

  logic [7:0] vec_d [3];
  logic       vec_p [3];

  initial begin
    int t;
    int cnt;
    vec_d = '{8'h00, 8'h03, 8'h07};
    vec_p = '{1'b1, 1'b1, 1'b0};
    bus.TX_DATA  = 8'h00;
    bus.TX_START = 1'b0;

    repeat (3) @(negedge CLK);
    check("reset_clk_oe", 32'(PS2_CLK_OE), 0);
    check("reset_data_oe", 32'(PS2_DATA_OE), 0);
    check("reset_busy_done_error", {29'd0, bus.BUSY, bus.DONE, bus.ERROR}, 0);
    check("reset_err_code", 32'(bus.ERR_CODE), 0);
    nRESET = 1'b1;
    repeat (20) @(negedge CLK);

    // 0xED with ACK; a request on the DONE cycle itself must be dropped.
    push_exp(1'b0, 2'd0, 1'b1, {1'b1, 1'b1, 8'hED, 1'b0});
    send(8'hED);
    fork
      dev_frame(11, 1'b1, 0);
      begin
        t = 0;
        while (!bus.DONE && t < 3000) begin @(negedge CLK); t++; end
        check("t1_done_seen", 32'(bus.DONE), 1);
        bus.TX_START = 1'b1;
        @(negedge CLK);
        bus.TX_START = 1'b0;
        check("start_on_done_ignored", 32'(bus.BUSY), 0);
      end
    join
    wait_resp(2000);
    check("t1_err_code_zero", 32'(bus.ERR_CODE), 0);

    for (int i = 0; i < 3; i++) begin
      push_exp(1'b0, 2'd0, 1'b1, {1'b1, vec_p[i], vec_d[i], 1'b0});
      send(vec_d[i]);
      dev_frame(11, 1'b1, 0);
      wait_resp(2000);
    end

    // Device never clocks: ERROR lands exactly START_TIMEOUT cycles after release.
    push_exp(1'b1, 2'd1, 1'b0, 11'd0);
    send(8'hA5);
    t = 0;
    while (PS2_CLK_OE && t < 200) begin @(negedge CLK); t++; end
    cnt = 0;
    while (!bus.ERROR && cnt < 2000) begin @(negedge CLK); cnt++; end
    check("start_timeout_cycles", 32'(cnt), 500);
    wait_resp(100);
    repeat (5) @(negedge CLK);
    check("err_code_held", 32'(bus.ERR_CODE), 1);

    // NACK at the 11th clock.
    push_exp(1'b1, 2'd3, 1'b0, 11'd0);
    send(8'h12);
    dev_frame(11, 1'b0, 0);
    wait_resp(2000);

    // Device stops after 5 clocks.
    push_exp(1'b1, 2'd2, 1'b0, 11'd0);
    send(8'h34);
    dev_frame(5, 1'b1, 0);
    wait_resp(1000);

    // Asynchronous reset while bit 3 (a zero, so data is driven) is on the wire.
    send(8'h52);
    dev_frame(4, 1'b0, 0);
    check("pre_reset_data_oe", 32'(PS2_DATA_OE), 1);
    #2 nRESET = 1'b0;
    #1;
    check("async_reset_oe", {30'd0, PS2_CLK_OE, PS2_DATA_OE}, 0);
    check("async_reset_busy", 32'(bus.BUSY), 0);
    repeat (3) @(negedge CLK);
    nRESET = 1'b1;
    repeat (20) @(negedge CLK);
    push_exp(1'b0, 2'd0, 1'b1, {1'b1, 1'b0, 8'h07, 1'b0});
    send(8'h07);
    dev_frame(11, 1'b1, 0);
    wait_resp(2000);

    // Request while busy is ignored; a 3-cycle clock glitch is filtered out.
    push_exp(1'b0, 2'd0, 1'b1, {1'b1, 1'b1, 8'hED, 1'b0});
    send(8'hED);
    fork
      dev_frame(11, 1'b1, 3);
      begin
        repeat (300) @(negedge CLK);
        bus.TX_DATA  = 8'h55;
        bus.TX_START = 1'b1;
        @(negedge CLK);
        bus.TX_START = 1'b0;
      end
    join
    wait_resp(2000);

    repeat (100) @(negedge CLK);
    check("queue_drained", 32'(exp_q.size()), 0);
    check("response_count", 32'(resp_cnt), 32'(exp_total));
    check("idle_at_end", {29'd0, bus.BUSY, PS2_CLK_OE, PS2_DATA_OE}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends one command byte to the attached keyboard (e.g. 0xED set-LEDs, 0xFF reset) and checks the device ACK.
- Sits beside the keyboard receive path on the same PS2_CLK/PS2_DATA pins and drives them open-drain through output-enable lines.
- The top level ties each pad to 0 when its OE=1; otherwise the pad is released (pulled up).

Parameters:
- INHIBIT_CYCLES, 3200: CLK cycles the host holds clock low before the start bit (100 us at 32 MHz).
- START_TIMEOUT, 480000: max CLK cycles from clock release to the first device falling edge (15 ms).
- BIT_TIMEOUT, 64000: max CLK cycles between successive device falling edges (2 ms).
- FILTER_LEN, 8: consecutive equal synchronised samples required before the filtered line level changes.

Ports:
- CLK  in  1  system clock
- nRESET  in  1  asynchronous active-low reset
- PS2_CLK  in  1  clock pad level (asynchronous)
- PS2_DATA  in  1  data pad level (asynchronous)
- PS2_CLK_OE  out  1  1 = drive clock pad low
- PS2_DATA_OE  out  1  1 = drive data pad low
- TX_DATA  in  8  byte to send, sampled when TX_START is accepted
- TX_START  in  1  single-cycle request
- BUSY  out  1  high from the cycle after acceptance until DONE/ERROR
- DONE  out  1  one-cycle pulse on successful ACK and bus idle
- ERROR  out  1  one-cycle pulse on failure
- ERR_CODE  out  2  0 none, 1 start timeout, 2 bit timeout, 3 NACK; held until next accepted TX_START

Behaviour:
- Reset: one clock, asynchronous active-low reset (nRESET); no other reset. All registers clear asynchronously when nRESET=0. Outputs after reset: PS2_CLK_OE=0, PS2_DATA_OE=0, BUSY=0, DONE=0, ERROR=0, ERR_CODE=0. State = IDLE. Reset mid-transfer releases both pads on the same edge.
- Input conditioning: both pads pass through a 2-FF synchroniser, then a filter. The filtered level flips only after FILTER_LEN consecutive samples of the opposite value. A device falling edge (fall) is filtered clock 1->0. Detection latency is 2+FILTER_LEN cycles.
- Shift register: 10 bits = {stop 1, parity, TX_DATA[7:0]}, sent LSB first. Parity is odd: parity = ~^TX_DATA. Edge counter is 4 bits. Timeout counter is 19 bits and resets on every fall.
- States:
  - IDLE: TX_START=1 is accepted. Latch data, clear ERR_CODE, go to INHIBIT. BUSY=1 the next cycle. TX_START is ignored in every other state.
  - INHIBIT: CLK_OE=1 for INHIBIT_CYCLES. On the last cycle set DATA_OE=1 (start bit 0). Go to REQ; CLK_OE=0 from REQ's first cycle.
  - REQ: wait for a fall. On fall, DATA_OE=~bit0 and go to SEND with edge count 1. If START_TIMEOUT elapses, fail with code 1.
  - SEND: on each fall, edge count increments and DATA_OE=~next bit. Falls 1-8 present data bits 0-7. Fall 9 presents parity. Fall 10 releases data (stop bit, DATA_OE=0). After fall 10 go to ACK. BIT_TIMEOUT between falls fails with code 2.
  - ACK: on fall 11, sample filtered data. 0 goes to WAIT_IDLE. 1 fails with code 3. BIT_TIMEOUT fails with code 2.
  - WAIT_IDLE: when filtered clock=1 and data=1, pulse DONE, set BUSY=0, go to IDLE. BIT_TIMEOUT fails with code 2.
- Fail: both OE=0 the same cycle, ERROR pulses one cycle, ERR_CODE is set, BUSY=0, go to IDLE.
- DONE and ERROR are never simultaneous. A new TX_START in the same cycle as the DONE/ERROR pulse is ignored; it is accepted from the following cycle.
- The receive path is not gated by this block. The device does not echo host frames as scan codes, so no interaction is required.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz and ACKing -> data sampled on rising edges is 0,1,0,1,1,0,1,1,1,1,1 (start, LSB-first 0xED, parity 1, stop 1). DONE pulses once, ERR_CODE=0, BUSY low after DONE.
- Send 0x00 -> parity bit=1. Send 0x03 -> parity=1. Send 0x07 -> parity=0. All three complete with DONE.
- Device never clocks (INHIBIT_CYCLES=20, START_TIMEOUT=500 in sim) -> ERROR exactly 500 cycles after clock release, ERR_CODE=1, both OE=0.
- Device holds data high at the 11th clock -> ERR_CODE=3, ERROR pulse, no DONE. Device stops after 5 clocks -> ERR_CODE=2 after BIT_TIMEOUT.
- Assert nRESET low during the 4th data bit -> both OE drop asynchronously, BUSY=0. A new TX_START after reset completes normally.
- TX_START pulsed while BUSY -> ignored and the original byte completes. A 3-cycle glitch on PS2_CLK with FILTER_LEN=8 -> no edge counted, frame unaffected.
